// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;
  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  function automatic logic is_div(op_e op);
    return op[2];
  endfunction
endpackage

// File: rtl/muldiv_if.sv
// Request/completion bundle between register-file read ports, muldiv_unit and write port 3.
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_addr;
  logic            busy;
  logic            done;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] result;

  modport master (output start, kill, op, rs1_data, rs2_data, rd_addr,
                  input  busy, done, rd_out, result);
  modport slave  (input  start, kill, op, rs1_data, rs2_data, rd_addr,
                  output busy, done, rd_out, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply or restoring divide over
// ITER cycles on magnitudes, sign fix-up in FIX, one-cycle done pulse in DONE.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  muldiv_if.slave  bus
);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state, state_nxt;
  op_e               op_in, op_q;
  logic              accept;
  logic              sgn_a, sgn_b, a_neg_in, b_neg_in;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_val;

  logic              a_neg, res_neg;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc, acc_nxt, mul_nxt, div_nxt, prod;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN:0]     mul_sum, div_part;
  logic              div_lt;
  logic [XLEN-1:0]   div_dif, quo, rem, fix_val;

  assign op_in  = op_e'(bus.op);
  assign accept = bus.start & ~bus.kill & (state == IDLE || state == DONE);

  // Operand decode at launch: magnitudes, sign flags and the short-circuit cases.
  always_comb begin
    sgn_a       = !(op_in == OP_MULHU || op_in == OP_DIVU || op_in == OP_REMU);
    sgn_b       = sgn_a && (op_in != OP_MULHSU);
    a_neg_in    = sgn_a & bus.rs1_data[XLEN-1];
    b_neg_in    = sgn_b & bus.rs2_data[XLEN-1];
    a_mag_in    = a_neg_in ? -bus.rs1_data : bus.rs1_data;
    b_mag_in    = b_neg_in ? -bus.rs2_data : bus.rs2_data;
    div_zero    = is_div(op_in) && (bus.rs2_data == '0);
    div_ovf     = (op_in == OP_DIV || op_in == OP_REM) &&
                  (bus.rs1_data == SMIN) && (bus.rs2_data == '1);
    special     = div_zero | div_ovf;
    special_val = '0;
    if (div_zero)
      special_val = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : bus.rs1_data;
    else if (op_in == OP_DIV)
      special_val = SMIN;
  end

  // One iteration. Multiply shifts the product right through acc; divide shifts
  // {rem, dividend/quotient} left and subtracts the divisor when it fits.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    mul_nxt  = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    div_part = acc[2*XLEN-1:XLEN-1];
    div_lt   = div_part < {1'b0, opnd};
    div_dif  = div_part[XLEN-1:0] - opnd;
    div_nxt  = {div_lt ? div_part[XLEN-1:0] : div_dif, acc[XLEN-2:0], ~div_lt};
    acc_nxt  = is_div(op_q) ? div_nxt : mul_nxt;
  end

  always_comb begin
    prod    = res_neg ? -acc : acc;
    quo     = res_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem     = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_val = rem;
    case (op_q)
      OP_MUL:                        fix_val = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_val = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_val = quo;
      default:                       fix_val = rem;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(ITER-1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = accept ? (special ? DONE : CALC) : IDLE;
    endcase
    if (bus.kill) state_nxt = IDLE;
  end

  always_comb begin
    bus.busy = (state == CALC) || (state == FIX);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_MUL;
      a_neg      <= 1'b0;
      res_neg    <= 1'b0;
      opnd       <= '0;
      acc        <= '0;
      cnt        <= '0;
      bus.rd_out <= '0;
      bus.result <= '0;
    end else if (accept) begin
      op_q       <= op_in;
      a_neg      <= a_neg_in;
      res_neg    <= a_neg_in ^ b_neg_in;
      opnd       <= is_div(op_in) ? b_mag_in : a_mag_in;
      acc        <= {{XLEN{1'b0}}, is_div(op_in) ? a_mag_in : b_mag_in};
      cnt        <= '0;
      bus.rd_out <= bus.rd_addr;
      if (special) bus.result <= special_val;
    end else if (!bus.kill && state == CALC) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
    end else if (!bus.kill && state == FIX) begin
      bus.result <= fix_val;
    end
  end
endmodule
